// File: rtl/line_window_gen_pkg.sv
// Shared types and helpers for the sliding-window generator.
package line_window_gen_pkg;

  typedef enum logic [1:0] {
    STRIDE_1 = 2'd1,
    STRIDE_2 = 2'd2
  } stride_e;

  // Bits occupied by one packed pixel.
  function automatic int pix_width(input int data_width, input int channel);
    return data_width * channel;
  endfunction

  // Bit offset of window element (r,c) inside the flattened window bus.
  function automatic int elem_offset(input int r, input int c, input int kernel, input int pix_w);
    return (r * kernel + c) * pix_w;
  endfunction

  // Map an integer stride parameter onto the supported set.
  function automatic stride_e to_stride(input int s);
    return (s == 2) ? STRIDE_2 : STRIDE_1;
  endfunction

endpackage

// File: rtl/line_window_gen_row_delay.sv
// One image row of pixel delay: output is the pixel accepted pDEPTH enables ago.
module row_delay #(
  parameter int pWIDTH = 8,
  parameter int pDEPTH = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [pWIDTH-1:0] din,
  output logic [pWIDTH-1:0] dout
);

  logic [pWIDTH-1:0] sr [pDEPTH];

  // Shift the row one position per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < pDEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < pDEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[pDEPTH-1];

endmodule

// File: rtl/line_window_gen.sv
// Streaming KxK window generator over a raster pixel stream ("valid" windows only).
module line_window_gen
  import line_window_gen_pkg::*;
#(
  parameter int pDATA_WIDTH = 8,
  parameter int pCHANNEL    = 1,
  parameter int pIMG_WIDTH  = 640,
  parameter int pIMG_HEIGHT = 480,
  parameter int pKERNEL     = 3,
  parameter int pSTRIDE     = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             valid_in,
  input  logic [pCHANNEL*pDATA_WIDTH-1:0]                  data_in,
  output logic                                             valid_out,
  output logic [pKERNEL*pKERNEL*pCHANNEL*pDATA_WIDTH-1:0]  window_out,
  output logic                                             frame_done
);

  localparam int      PIX_W  = pix_width(pDATA_WIDTH, pCHANNEL);
  localparam int      WIN_W  = pKERNEL * pKERNEL * PIX_W;
  localparam int      COL_W  = $clog2(pIMG_WIDTH);
  localparam int      ROW_W  = $clog2(pIMG_HEIGHT);
  localparam stride_e STRIDE = to_stride(pSTRIDE);
  // Parity of pKERNEL-1: with stride 2 a position is on-grid when its parity matches.
  localparam logic    K1_LSB = 1'((pKERNEL - 1) % 2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;
  logic             win_ok;

  // tap[pKERNEL-1] is the live pixel; lower indices are progressively older rows.
  logic [PIX_W-1:0] tap  [pKERNEL];
  // hist[r][c] holds the pixels left of the live column for row tap r (c=0 oldest).
  logic [PIX_W-1:0] hist [pKERNEL][pKERNEL-1];
  logic [WIN_W-1:0] win;

  assign tap[pKERNEL-1] = data_in;

  // Chain of row delays; contents need no clearing since validity comes from counters.
  for (genvar i = 0; i < pKERNEL - 1; i++) begin : g_rows
    row_delay #(
      .pWIDTH (PIX_W),
      .pDEPTH (pIMG_WIDTH)
    ) u_row_delay (
      .clk  (clk),
      .rst  (1'b0),
      .en   (valid_in),
      .din  (tap[pKERNEL-1-i]),
      .dout (tap[pKERNEL-2-i])
    );
  end

  // Per-row column history, advancing with each accepted pixel.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int r = 0; r < pKERNEL; r++) begin
        for (int c = 0; c < pKERNEL - 2; c++) hist[r][c] <= hist[r][c+1];
        hist[r][pKERNEL-2] <= tap[r];
      end
    end
  end

  // Assemble the window seen by the pixel currently on data_in.
  always_comb begin
    win = '0;
    for (int r = 0; r < pKERNEL; r++) begin
      for (int c = 0; c < pKERNEL - 1; c++) begin
        win[elem_offset(r, c, pKERNEL, PIX_W) +: PIX_W] = hist[r][c];
      end
      win[elem_offset(r, pKERNEL - 1, pKERNEL, PIX_W) +: PIX_W] = tap[r];
    end
  end

  assign col_last = (col == COL_W'(pIMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(pIMG_HEIGHT - 1));

  // A window is complete only when the full KxK block lies inside the current frame.
  always_comb begin
    win_ok = (row >= ROW_W'(pKERNEL - 1)) && (col >= COL_W'(pKERNEL - 1));
    if (STRIDE == STRIDE_2) begin
      win_ok = win_ok && (row[0] == K1_LSB) && (col[0] == K1_LSB);
    end
  end

  // Position counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (win_ok) begin
          valid_out  <= 1'b1;
          window_out <= win;
        end
        frame_done <= col_last && row_last;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench: 4x4 stride-1 instance (a) and 5x5 stride-2 instance (b).
module tb_line_window_gen;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int WW = K * K * DW;
  localparam int AW = 4, AH = 4;
  localparam int BW = 5, BH = 5;

  typedef struct {
    logic [WW-1:0] win;
    logic          fd;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, valid_a, vout_a, fd_a;
  logic [DW-1:0] data_a;
  logic [WW-1:0] wout_a;
  logic          rst_b, valid_b, vout_b, fd_b;
  logic [DW-1:0] data_b;
  logic [WW-1:0] wout_b;

  line_window_gen #(.pDATA_WIDTH(DW), .pCHANNEL(1), .pIMG_WIDTH(AW), .pIMG_HEIGHT(AH),
                    .pKERNEL(K), .pSTRIDE(1)) dut_a (
    .clk(clk), .rst(rst_a), .valid_in(valid_a), .data_in(data_a),
    .valid_out(vout_a), .window_out(wout_a), .frame_done(fd_a));

  line_window_gen #(.pDATA_WIDTH(DW), .pCHANNEL(1), .pIMG_WIDTH(BW), .pIMG_HEIGHT(BH),
                    .pKERNEL(K), .pSTRIDE(2)) dut_b (
    .clk(clk), .rst(rst_b), .valid_in(valid_b), .data_in(data_b),
    .valid_out(vout_b), .window_out(wout_b), .frame_done(fd_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t          qa[$], qb[$];
  int            fqa[$], fqb[$];
  logic [WW-1:0] loga[$], logb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Window whose top-left pixel is (r0,c0) in an image of width w, values row*w+col+1+base.
  function automatic logic [WW-1:0] make_win(input int r0, input int c0, input int w, input int base);
    logic [WW-1:0] v;
    int            p;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        p = (r0 + r) * w + (c0 + c) + 1 + base;
        v[(r * K + c) * DW +: DW] = DW'(p);
      end
    return v;
  endfunction

  function automatic logic [WW-1:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {DW'(e8), DW'(e7), DW'(e6), DW'(e5), DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  // Monitors: pop expectations whenever the DUT presents a window or frame_done.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (vout_a) begin
      loga.push_back(wout_a);
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_window: got %h at cycle %0d, expected none", wout_a, cyc);
      end else begin
        e = qa.pop_front();
        check("a_window", wout_a, e.win);
        check("a_latency", WW'(cyc), WW'(e.due));
        check("a_fd_with_window", WW'(fd_a), WW'(e.fd));
      end
    end
    if (fd_a) begin
      if (fqa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_frame_done: got 1 at cycle %0d, expected 0", cyc);
      end else begin
        d = fqa.pop_front();
        check("a_frame_done_cycle", WW'(cyc), WW'(d));
      end
    end
    if (vout_b) begin
      logb.push_back(wout_b);
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_window: got %h at cycle %0d, expected none", wout_b, cyc);
      end else begin
        e = qb.pop_front();
        check("b_window", wout_b, e.win);
        check("b_latency", WW'(cyc), WW'(e.due));
        check("b_fd_with_window", WW'(fd_b), WW'(e.fd));
      end
    end
    if (fd_b) begin
      if (fqb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_frame_done: got 1 at cycle %0d, expected 0", cyc);
      end else begin
        d = fqb.pop_front();
        check("b_frame_done_cycle", WW'(cyc), WW'(d));
      end
    end
  end

  task automatic drive_a(input int r, input int c, input int base);
    exp_t e;
    bit   last;
    @(negedge clk);
    valid_a = 1'b1;
    data_a  = DW'(r * AW + c + 1 + base);
    last    = (r == AH - 1) && (c == AW - 1);
    if (r >= K - 1 && c >= K - 1) begin
      e.win = make_win(r - (K - 1), c - (K - 1), AW, base);
      e.fd  = last;
      e.due = cyc + 1;
      qa.push_back(e);
    end
    if (last) fqa.push_back(cyc + 1);
  endtask

  task automatic drive_b(input int r, input int c, input int base);
    exp_t e;
    bit   last;
    @(negedge clk);
    valid_b = 1'b1;
    data_b  = DW'(r * BW + c + 1 + base);
    last    = (r == BH - 1) && (c == BW - 1);
    if (r >= K - 1 && c >= K - 1 && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0)) begin
      e.win = make_win(r - (K - 1), c - (K - 1), BW, base);
      e.fd  = last;
      e.due = cyc + 1;
      qb.push_back(e);
    end
    if (last) fqb.push_back(cyc + 1);
  endtask

  task automatic bubble_a();
    @(negedge clk);
    valid_a = 1'b0;
    data_a  = 8'hEE;
  endtask

  task automatic frame_a(input int base, input bit bubbles);
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        if (bubbles) begin
          for (int n = 0; n < 3; n++) begin
            if ($urandom_range(1) == 0) break;
            bubble_a();
          end
        end
        drive_a(r, c, base);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  initial begin
    int n0;
    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    idle(3);
    check("reset_valid_out_a", WW'(vout_a), '0);
    check("reset_window_out_a", wout_a, '0);
    check("reset_frame_done_a", WW'(fd_a), '0);
    check("reset_valid_out_b", WW'(vout_b), '0);
    check("reset_window_out_b", wout_b, '0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Continuous frame
    n0 = loga.size();
    frame_a(0, 1'b0);
    idle(3);
    check("t1_count", WW'(loga.size() - n0), WW'(4));
    if (loga.size() >= n0 + 4) begin
      check("t1_first", loga[n0], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      check("t1_last", loga[n0 + 3], pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    end

    // Same frame with bubbles
    n0 = loga.size();
    frame_a(0, 1'b1);
    idle(3);
    check("t2_count", WW'(loga.size() - n0), WW'(4));

    // Stride 2 on 5x5
    n0 = logb.size();
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) drive_b(r, c, 0);
    idle(3);
    check("t3_count", WW'(logb.size() - n0), WW'(4));
    if (logb.size() >= n0 + 1)
      check("t3_first", logb[n0], pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));

    // Back-to-back frames
    n0 = loga.size();
    frame_a(0, 1'b0);
    frame_a(100, 1'b0);
    idle(3);
    check("t4_count", WW'(loga.size() - n0), WW'(8));
    if (loga.size() >= n0 + 5)
      check("t4_frame2_first", loga[n0 + 4], pack9(101, 102, 103, 105, 106, 107, 109, 110, 111));

    // Reset after 7 pixels
    for (int i = 0; i < 7; i++) drive_a(i / AW, i % AW, 50);
    @(negedge clk);
    rst_a = 1'b1; valid_a = 1'b1; data_a = 8'h77;
    @(negedge clk);
    check("t5_valid_during_reset", WW'(vout_a), '0);
    @(negedge clk);
    check("t5_valid_during_reset2", WW'(vout_a), '0);
    rst_a = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    check("t5_valid_after_reset", WW'(vout_a), '0);
    check("t5_window_after_reset", wout_a, '0);
    check("t5_fd_after_reset", WW'(fd_a), '0);
    n0 = loga.size();
    frame_a(0, 1'b1);
    idle(3);
    check("t5_count", WW'(loga.size() - n0), WW'(4));
    if (loga.size() >= n0 + 1)
      check("t5_first", loga[n0], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    idle(2);
    check("a_pending_windows", WW'(qa.size()), '0);
    check("a_pending_frame_done", WW'(fqa.size()), '0);
    check("b_pending_windows", WW'(qb.size()), '0);
    check("b_pending_frame_done", WW'(fqb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
